// File: rtl/burst_sweep_ctrl.sv
// ============================================================================
// burst_sweep_ctrl
// ----------------------------------------------------------------------------
// Self-test sequencer for a (41,32) burst-3 encoder/decoder pair. It latches
// one message, then walks an XOR error mask across every burst start position
// and every B-bit burst pattern. Each vector is held for SETTLE cycles and
// then compared for one cycle against the decoder output. The block counts
// failing vectors and records the first one.
//
// Ports
//   clk              rising-edge clock
//   rst              synchronous reset, active-high
//   start            begin a sweep (honoured in IDLE/DONE only)
//   abort            stop the sweep and return to IDLE without done
//   msg_in   [K]     message to test, latched in LOAD
//   msg_out  [K]     latched message, drives the encoder input
//   err_mask [0:N-1] XOR mask applied to the codeword; bit 0 is the MSB
//   dec_msg_in [K]   decoder output
//   busy             high in LOAD/APPLY/CHECK
//   done             high in DONE
//   pass             done with zero failures
//   fail_count [CW]  failing vectors in the current/last sweep (saturating)
//   first_fail_valid at least one vector has failed
//   first_fail_pos   burst start position of the first failing vector
//   first_fail_pat   burst pattern of the first failing vector
// ============================================================================
module burst_sweep_ctrl #(
    parameter int N      = 41,
    parameter int K      = 32,
    parameter int B      = 3,
    parameter int SETTLE = 2,
    parameter int CW     = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [K-1:0]  msg_in,
    output logic [K-1:0]  msg_out,
    output logic [0:N-1]  err_mask,
    input  logic [K-1:0]  dec_msg_in,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [CW-1:0] fail_count,
    output logic          first_fail_valid,
    output logic [5:0]    first_fail_pos,
    output logic [B-1:0]  first_fail_pat
);

    localparam int LAST_POS = N - B;
    localparam int SW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_APPLY,
        S_CHECK,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [5:0]    pos;
    logic [B-1:0]  pat;
    logic [SW-1:0] settle_cnt;
    logic          last_vec;
    logic          mismatch;
    logic [0:N-1]  burst;

    assign last_vec = (pos == 6'(LAST_POS)) && (&pat);
    assign mismatch = (dec_msg_in != msg_out);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // ------------------------------------------------------------------
    // Next-state logic; abort dominates start and every sweep transition
    // ------------------------------------------------------------------
    // NOTE: the default assignment up front keeps this block free of latches.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (abort)      state_nx = S_IDLE;
                else if (start) state_nx = S_LOAD;
            end
            S_LOAD:  state_nx = abort ? S_IDLE : S_APPLY;
            S_APPLY: begin
                if (abort)                 state_nx = S_IDLE;
                else if (settle_cnt == '0) state_nx = S_CHECK;
            end
            S_CHECK: begin
                if (abort)         state_nx = S_IDLE;
                else if (last_vec) state_nx = S_DONE;
                else               state_nx = S_APPLY;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Sweep datapath: message latch, vector counters, result capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            msg_out          <= '0;
            pos              <= '0;
            pat              <= '0;
            settle_cnt       <= '0;
            fail_count       <= '0;
            first_fail_valid <= 1'b0;
            first_fail_pos   <= '0;
            first_fail_pat   <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start && !abort) begin
                        fail_count       <= '0;
                        first_fail_valid <= 1'b0;
                        first_fail_pos   <= '0;
                        first_fail_pat   <= '0;
                    end
                end
                S_LOAD: begin
                    msg_out    <= msg_in;
                    pos        <= '0;
                    pat        <= '0;
                    settle_cnt <= SW'(SETTLE - 1);
                end
                S_APPLY: begin
                    if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
                end
                S_CHECK: begin
                    // An abort in the compare cycle discards that compare.
                    if (!abort) begin
                        if (mismatch) begin
                            if (fail_count != '1) fail_count <= fail_count + 1'b1;
                            if (!first_fail_valid) begin
                                first_fail_valid <= 1'b1;
                                first_fail_pos   <= pos;
                                first_fail_pat   <= pat;
                            end
                        end
                        if (!last_vec) begin
                            settle_cnt <= SW'(SETTLE - 1);
                            pat        <= pat + 1'b1;
                            if (&pat) pos <= pos + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs: the burst is left-aligned at bit 0 (pattern MSB first) and
    // shifted towards higher indices by pos.
    // ------------------------------------------------------------------
    always_comb begin
        burst    = {pat, {(N-B){1'b0}}};
        busy     = (state == S_LOAD) || (state == S_APPLY) || (state == S_CHECK);
        done     = (state == S_DONE);
        pass     = done && (fail_count == '0);
        err_mask = '0;
        if ((state == S_APPLY) || (state == S_CHECK)) err_mask = burst >> pos;
    end

endmodule

// File: tb/tb_burst_sweep_ctrl.sv
// ============================================================================
// tb_burst_sweep_ctrl
// ----------------------------------------------------------------------------
// Bench for burst_sweep_ctrl. A decoder stub (ideal / inverting / faulting on
// chosen mask values) closes the loop; expected results come from a sweep
// model that enumerates vectors arithmetically.
// ============================================================================
module tb_burst_sweep_ctrl;

    localparam int N           = 41;
    localparam int K           = 32;
    localparam int B           = 3;
    localparam int SETTLE      = 2;
    localparam int CW          = 10;
    localparam int NPAT        = 1 << B;
    localparam int NPOS        = N - B + 1;
    localparam int V           = NPOS * NPAT;
    localparam int VEC_CYC     = SETTLE + 1;
    localparam int SWEEP_EDGES = 1 + V * VEC_CYC;

    typedef logic [0:N-1] mask_t;
    typedef enum int {DEC_IDEAL, DEC_INVERT, DEC_FAULTS} dec_mode_t;

    typedef struct {
        int fails;
        bit ffv;
        int ffpos;
        int ffpat;
    } sweep_res_t;

    typedef struct {
        bit    rst;
        bit    start;
        bit    abort;
        bit    exp_busy;
        bit    exp_done;
        mask_t exp_mask;
        string name;
    } ctl_vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [K-1:0]  msg_in = '0;
    logic [K-1:0]  msg_out;
    mask_t         err_mask;
    logic [K-1:0]  dec_msg_in = '0;
    logic          busy;
    logic          done;
    logic          pass;
    logic [CW-1:0] fail_count;
    logic          first_fail_valid;
    logic [5:0]    first_fail_pos;
    logic [B-1:0]  first_fail_pat;

    burst_sweep_ctrl #(
        .N(N), .K(K), .B(B), .SETTLE(SETTLE), .CW(CW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .abort            (abort),
        .msg_in           (msg_in),
        .msg_out          (msg_out),
        .err_mask         (err_mask),
        .dec_msg_in       (dec_msg_in),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .fail_count       (fail_count),
        .first_fail_valid (first_fail_valid),
        .first_fail_pos   (first_fail_pos),
        .first_fail_pat   (first_fail_pat)
    );

    always #5 clk = ~clk;

    int        n_checks = 0;
    int        n_fail   = 0;
    dec_mode_t dec_mode = DEC_IDEAL;
    mask_t     fault_masks[$];

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Mask of vector (p,t) as a number: the B-bit pattern sits at the LSB end
    // (indices N-B..N-1) and moves left by N-B-p places.
    function automatic mask_t model_mask(input int p, input int t);
        longint unsigned v;
        v = longint'(t) << (N - B - p);
        return v[N-1:0];
    endfunction

    function automatic bit mask_is_faulty(input mask_t m);
        foreach (fault_masks[i]) if (fault_masks[i] == m) return 1'b1;
        return 1'b0;
    endfunction

    // Expected result after the first nvec vectors of a sweep.
    function automatic sweep_res_t model_sweep(input dec_mode_t mode, input int nvec);
        sweep_res_t r;
        int p;
        int t;
        bit bad;
        r.fails = 0; r.ffv = 1'b0; r.ffpos = 0; r.ffpat = 0;
        for (int v = 0; v < nvec; v++) begin
            p = v / NPAT;
            t = v % NPAT;
            case (mode)
                DEC_IDEAL:  bad = 1'b0;
                DEC_INVERT: bad = 1'b1;
                default:    bad = mask_is_faulty(model_mask(p, t));
            endcase
            if (bad) begin
                if (r.fails < (1 << CW) - 1) r.fails++;
                if (!r.ffv) begin
                    r.ffv = 1'b1; r.ffpos = p; r.ffpat = t;
                end
            end
        end
        return r;
    endfunction

    // Decoder stub, refreshed mid-cycle from the current mask and message.
    always @(negedge clk) begin
        case (dec_mode)
            DEC_IDEAL:  dec_msg_in = msg_out;
            DEC_INVERT: dec_msg_in = ~msg_out;
            default:    dec_msg_in = mask_is_faulty(err_mask) ? (msg_out ^ {{(K-1){1'b0}}, 1'b1}) : msg_out;
        endcase
    end

    // Pulse start, then follow the sweep edge by edge up to stop_k edges,
    // comparing every cycle's mask with the vector the timing says is active.
    task automatic run_sweep(input logic [K-1:0] msg, input bit poke, input int stop_k,
                             output int done_edge, output int mask_errs, output mask_t last_mask);
        int    first_bad;
        mask_t exp_m;
        done_edge = -1; mask_errs = 0; last_mask = '0; first_bad = -1;
        @(negedge clk);
        msg_in = msg; start = 1'b1; abort = 1'b0;
        @(negedge clk);
        start = 1'b0;
        if (err_mask !== '0 || !busy) mask_errs++;
        for (int k = 1; k <= stop_k; k++) begin
            @(negedge clk);
            if (done) begin
                done_edge = k;
                break;
            end
            if (k <= V * VEC_CYC) exp_m = model_mask(((k - 1) / VEC_CYC) / NPAT, ((k - 1) / VEC_CYC) % NPAT);
            else                  exp_m = '0;
            if (err_mask !== exp_m || !busy) begin
                mask_errs++;
                if (first_bad < 0) first_bad = k;
            end
            if (k == V * VEC_CYC) last_mask = err_mask;
            if (poke) begin
                start  = ($urandom_range(0, 5) == 0);
                msg_in = $urandom;
            end
        end
        start = 1'b0;
        if (first_bad >= 0) $display("  first mask deviation after edge %0d", first_bad);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ctl_vec_t      tbl[17];
        sweep_res_t    exp_r;
        int            done_edge;
        int            mask_errs;
        int            done_seen;
        mask_t         last_mask;
        mask_t         m;
        logic [K-1:0]  msg;

        // ---------------- reset state ----------------
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst pass", pass, 0);
        check("rst mask", err_mask, 0);
        check("rst msg_out", msg_out, 0);
        check("rst fail_count", fail_count, 0);
        check("rst first_fail_valid", first_fail_valid, 0);
        check("rst first_fail_pos", first_fail_pos, 0);
        check("rst first_fail_pat", first_fail_pat, 0);

        // ---------------- control table ----------------
        tbl[0]  = '{1, 0, 0, 0, 0, '0, "reset"};
        tbl[1]  = '{0, 0, 0, 0, 0, '0, "idle hold"};
        tbl[2]  = '{0, 1, 1, 0, 0, '0, "idle start+abort"};
        tbl[3]  = '{0, 0, 1, 0, 0, '0, "idle abort"};
        tbl[4]  = '{0, 1, 0, 1, 0, '0, "idle start"};
        tbl[5]  = '{0, 0, 0, 1, 0, '0, "load to apply"};
        tbl[6]  = '{0, 0, 1, 0, 0, '0, "apply abort"};
        tbl[7]  = '{0, 1, 0, 1, 0, '0, "restart"};
        tbl[8]  = '{1, 1, 0, 0, 0, '0, "rst beats start"};
        tbl[9]  = '{0, 1, 0, 1, 0, '0, "start after rst"};
        tbl[10] = '{0, 1, 1, 0, 0, '0, "load abort"};
        tbl[11] = '{0, 1, 0, 1, 0, '0, "start again"};
        tbl[12] = '{0, 0, 0, 1, 0, '0, "apply v0 a"};
        tbl[13] = '{0, 0, 0, 1, 0, '0, "apply v0 b"};
        tbl[14] = '{0, 0, 0, 1, 0, '0, "check v0"};
        tbl[15] = '{0, 1, 0, 1, 0, model_mask(0, 1), "start ignored busy"};
        tbl[16] = '{0, 0, 1, 0, 0, '0, "abort v1"};
        for (int i = 0; i < 17; i++) begin
            rst = tbl[i].rst; start = tbl[i].start; abort = tbl[i].abort;
            @(negedge clk);
            check({tbl[i].name, " busy"}, busy, tbl[i].exp_busy);
            check({tbl[i].name, " done"}, done, tbl[i].exp_done);
            check({tbl[i].name, " mask"}, err_mask, tbl[i].exp_mask);
        end
        rst = 1'b0; start = 1'b0; abort = 1'b0;

        // ---------------- ideal decoder, all-ones message ----------------
        dec_mode = DEC_IDEAL;
        fault_masks.delete();
        run_sweep(32'hFFFF_FFFF, 1'b0, SWEEP_EDGES + 8, done_edge, mask_errs, last_mask);
        m = '0; m[38] = 1'b1; m[39] = 1'b1; m[40] = 1'b1;
        check("ideal done latency", done_edge, SWEEP_EDGES);
        check("ideal mask sequence errors", mask_errs, 0);
        check("ideal last mask", last_mask, m);
        check("ideal fail_count", fail_count, 0);
        check("ideal pass", pass, 1);
        check("ideal first_fail_valid", first_fail_valid, 0);
        check("ideal msg_out", msg_out, 32'hFFFF_FFFF);
        check("ideal mask in done", err_mask, 0);
        repeat (3) @(negedge clk);
        check("ideal done held", done, 1);

        // ---------------- single fault at pos 5, pattern 101 ----------------
        dec_mode = DEC_FAULTS;
        m = '0; m[5] = 1'b1; m[7] = 1'b1;
        fault_masks.push_back(m);
        run_sweep(32'h1234_5678, 1'b0, SWEEP_EDGES + 8, done_edge, mask_errs, last_mask);
        check("fault5 done latency", done_edge, SWEEP_EDGES);
        check("fault5 fail_count", fail_count, 1);
        check("fault5 first_fail_valid", first_fail_valid, 1);
        check("fault5 first_fail_pos", first_fail_pos, 5);
        check("fault5 first_fail_pat", first_fail_pat, 3'b101);
        check("fault5 pass", pass, 0);

        // ---------------- inverting decoder: every vector fails ----------------
        dec_mode = DEC_INVERT;
        run_sweep(32'hA5A5_0F0F, 1'b0, SWEEP_EDGES + 8, done_edge, mask_errs, last_mask);
        check("invert done latency", done_edge, SWEEP_EDGES);
        check("invert fail_count", fail_count, V);
        check("invert first_fail_valid", first_fail_valid, 1);
        check("invert first_fail_pos", first_fail_pos, 0);
        check("invert first_fail_pat", first_fail_pat, 0);
        check("invert pass", pass, 0);

        // ---------------- random fault sets with busy-time pokes ----------------
        dec_mode = DEC_FAULTS;
        for (int r = 0; r < 3; r++) begin
            fault_masks.delete();
            repeat ($urandom_range(1, 4)) fault_masks.push_back(model_mask($urandom_range(0, NPOS - 1), $urandom_range(0, NPAT - 1)));
            msg   = $urandom;
            exp_r = model_sweep(DEC_FAULTS, V);
            run_sweep(msg, 1'b1, SWEEP_EDGES + 8, done_edge, mask_errs, last_mask);
            check($sformatf("rand%0d done latency", r), done_edge, SWEEP_EDGES);
            check($sformatf("rand%0d mask sequence errors", r), mask_errs, 0);
            check($sformatf("rand%0d fail_count", r), fail_count, exp_r.fails);
            check($sformatf("rand%0d first_fail_valid", r), first_fail_valid, exp_r.ffv);
            check($sformatf("rand%0d first_fail_pos", r), first_fail_pos, exp_r.ffpos);
            check($sformatf("rand%0d first_fail_pat", r), first_fail_pat, exp_r.ffpat);
            check($sformatf("rand%0d pass", r), pass, exp_r.fails == 0);
            check($sformatf("rand%0d msg_out", r), msg_out, msg);
        end

        // ---------------- reset in APPLY of vector 100 ----------------
        dec_mode = DEC_INVERT;
        run_sweep(32'hDEAD_BEEF, 1'b0, 1 + VEC_CYC * 100, done_edge, mask_errs, last_mask);
        exp_r = model_sweep(DEC_INVERT, 100);
        check("midrst no early done", done_edge, -1);
        check("midrst mask sequence errors", mask_errs, 0);
        check("midrst partial fail_count", fail_count, exp_r.fails);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst busy", busy, 0);
        check("midrst done", done, 0);
        check("midrst mask", err_mask, 0);
        check("midrst fail_count", fail_count, 0);
        check("midrst first_fail_valid", first_fail_valid, 0);
        check("midrst msg_out", msg_out, 0);
        dec_mode = DEC_IDEAL;
        run_sweep(32'h0000_0001, 1'b0, SWEEP_EDGES + 8, done_edge, mask_errs, last_mask);
        check("postrst done latency", done_edge, SWEEP_EDGES);
        check("postrst pass", pass, 1);

        // ---------------- abort in the last CHECK, pokes while busy ----------------
        run_sweep(32'h5555_AAAA, 1'b1, V * VEC_CYC, done_edge, mask_errs, last_mask);
        check("abort mask sequence errors", mask_errs, 0);
        check("abort no early done", done_edge, -1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort mask", err_mask, 0);
        check("abort fail_count", fail_count, 0);
        done_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("abort done never asserts", done_seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
